// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word geometry.
package loader_pkg;

   // Loader FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // An instruction word is assembled from this many little-endian bytes.
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_WIDTH     = BYTES_PER_WORD * 8;
   localparam int IDX_WIDTH      = $clog2(BYTES_PER_WORD);

endpackage : loader_pkg

// File: rtl/prog_loader_word_assembler.sv
// Collects a little-endian byte stream into instruction words. It flags the
// strobe that completes a word and exposes the word including that byte.
module word_assembler
   import loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  byte_strobe,
   input  logic [7:0]            byte_data,
   output logic                  word_full,
   output logic [WORD_WIDTH-1:0] word_next
);

   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;

   // Next byte index and word contents; a clear wins over a byte strobe.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      idx_d  = idx_q;
      word_d = word_q;
      if (clear) begin
         idx_d  = '0;
         word_d = '0;
      end else if (byte_strobe) begin
         word_d[8*idx_q +: 8] = byte_data;
         idx_d                = idx_q + 1'b1;
      end
   end

   // The transfer into the last byte lane completes the word.
   always_comb begin
      word_full = byte_strobe && (idx_q == IDX_WIDTH'(BYTES_PER_WORD - 1));
      word_next = word_d;
   end

   // Byte index and word register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule : word_assembler

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream, writes whole words into instruction
// memory at consecutive addresses, and releases the core once the load ends.
module prog_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  START,
   input  logic [ADDR_WIDTH:0]   WORD_COUNT,
   input  logic                  BYTE_VALID,
   input  logic [7:0]            BYTE_DATA,
   output logic                  BYTE_READY,
   output logic [ADDR_WIDTH-1:0] ADDR_W,
   output logic                  ENABLE_W,
   output logic [DATA_WIDTH-1:0] Q_W,
   output logic                  CORE_RESET_N,
   output logic                  BUSY,
   output logic                  DONE
);

   // Largest loadable count: the whole memory.
   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   loader_pkg::state_e     state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
   logic [ADDR_WIDTH:0]    count_q, count_d;
   logic                   byte_ready_q, byte_ready_d;
   logic                   enable_w_q, enable_w_d;
   logic [ADDR_WIDTH-1:0]  addr_w_q, addr_w_d;
   logic [DATA_WIDTH-1:0]  q_w_q, q_w_d;
   logic                   core_reset_n_q, core_reset_n_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                               asm_clear;
   logic                               byte_strobe;
   logic                               word_full;
   logic [loader_pkg::WORD_WIDTH-1:0]  word_next;

   word_assembler u_word_assembler (
      .clk         (CLK),
      .rst_n       (RESET_N),
      .clear       (asm_clear),
      .byte_strobe (byte_strobe),
      .byte_data   (BYTE_DATA),
      .word_full   (word_full),
      .word_next   (word_next)
   );

   // Next-state, counter and registered-output logic. Outputs are decoded from
   // the next state so they are flops and BYTE_READY never depends on BYTE_VALID.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      count_d     = count_q;
      addr_w_d    = addr_w_q;
      q_w_d       = q_w_q;
      asm_clear   = 1'b0;
      byte_strobe = BYTE_VALID && byte_ready_q;

      case (state_q)
         loader_pkg::IDLE, loader_pkg::DONE: begin
            if (START) begin
               asm_clear = 1'b1;
               addr_d    = '0;
               cnt_d     = '0;
               count_d   = (WORD_COUNT > MAX_WORDS) ? MAX_WORDS : WORD_COUNT;
               state_d   = (WORD_COUNT == '0) ? loader_pkg::DONE : loader_pkg::RECV;
            end
         end
         loader_pkg::RECV: begin
            if (word_full) begin
               state_d  = loader_pkg::WRITE;
               addr_w_d = addr_q;
               q_w_d    = DATA_WIDTH'(word_next);
            end
         end
         loader_pkg::WRITE: begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d == count_q) ? loader_pkg::DONE : loader_pkg::RECV;
         end
         default: state_d = loader_pkg::IDLE;
      endcase

      byte_ready_d   = (state_d == loader_pkg::RECV);
      enable_w_d     = (state_d == loader_pkg::WRITE);
      busy_d         = (state_d == loader_pkg::RECV) || (state_d == loader_pkg::WRITE);
      done_d         = (state_d == loader_pkg::DONE);
      core_reset_n_d = (state_d == loader_pkg::DONE);
   end

   // FSM, counters and output registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q        <= loader_pkg::IDLE;
         addr_q         <= '0;
         cnt_q          <= '0;
         count_q        <= '0;
         byte_ready_q   <= 1'b0;
         enable_w_q     <= 1'b0;
         addr_w_q       <= '0;
         q_w_q          <= '0;
         core_reset_n_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         cnt_q          <= cnt_d;
         count_q        <= count_d;
         byte_ready_q   <= byte_ready_d;
         enable_w_q     <= enable_w_d;
         addr_w_q       <= addr_w_d;
         q_w_q          <= q_w_d;
         core_reset_n_q <= core_reset_n_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign BYTE_READY   = byte_ready_q;
   assign ENABLE_W     = enable_w_q;
   assign ADDR_W       = addr_w_q;
   assign Q_W          = q_w_q;
   assign CORE_RESET_N = core_reset_n_q;
   assign BUSY         = busy_q;
   assign DONE         = done_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader.
module tb_prog_loader;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW:0]   word_count;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic [AW-1:0] addr_w;
   logic          enable_w;
   logic [DW-1:0] q_w;
   logic          core_reset_n;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit stuck  = 1'b0;

   int          log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];

   prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .CLK          (clk),
      .RESET_N      (rst_n),
      .START        (start),
      .WORD_COUNT   (word_count),
      .BYTE_VALID   (byte_valid),
      .BYTE_DATA    (byte_data),
      .BYTE_READY   (byte_ready),
      .ADDR_W       (addr_w),
      .ENABLE_W     (enable_w),
      .Q_W          (q_w),
      .CORE_RESET_N (core_reset_n),
      .BUSY         (busy),
      .DONE         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every write strobe seen mid-cycle.
   always @(negedge clk) begin
      if (enable_w) begin
         log_addr.push_back(int'(addr_w));
         log_data.push_back(q_w);
         log_cyc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   // Present a byte and wait for the edge that transfers it; BYTE_VALID stays high.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n          = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 50 && !stuck) begin
         tick();
         n++;
      end
      check("byte_ready_wait", byte_ready, 1'b1);
      if (byte_ready) tick();
      else stuck = 1'b1;
   endtask

   task automatic start_load(input logic [AW:0] wc);
      start      = 1'b1;
      word_count = wc;
      tick();
      start      = 1'b0;
   endtask

   initial begin
      logic [31:0] t2_words [3];
      int          bad;
      t2_words = '{32'h13121110, 32'h17161514, 32'h1B1A1918};

      rst_n      = 1'b0;
      start      = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (3) tick();
      check("rst_byte_ready", byte_ready, 1'b0);
      check("rst_enable_w", enable_w, 1'b0);
      check("rst_addr_w", addr_w, '0);
      check("rst_q_w", q_w, '0);
      check("rst_core_reset_n", core_reset_n, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);

      // Single word 0x00500513.
      clear_log();
      start_load(11'd1);
      check("t1_busy", busy, 1'b1);
      check("t1_ready", byte_ready, 1'b1);
      check("t1_core_rst", core_reset_n, 1'b0);
      send_byte(8'h13);
      send_byte(8'h05);
      send_byte(8'h50);
      send_byte(8'h00);
      byte_valid = 1'b0;
      check("t1_enable_w", enable_w, 1'b1);
      check("t1_addr_w", addr_w, 10'd0);
      check("t1_q_w", q_w, 32'h00500513);
      check("t1_ready_in_write", byte_ready, 1'b0);
      tick();
      check("t1_done", done, 1'b1);
      check("t1_core_rst_done", core_reset_n, 1'b1);
      check("t1_enable_off", enable_w, 1'b0);
      check("t1_busy_off", busy, 1'b0);
      check("t1_q_w_hold", q_w, 32'h00500513);
      check("t1_write_count", log_addr.size(), 1);

      // Three words, BYTE_VALID held high: writes 5 cycles apart.
      clear_log();
      start_load(11'd3);
      check("t2_core_rst", core_reset_n, 1'b0);
      check("t2_done_low", done, 1'b0);
      for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i));
      byte_valid = 1'b0;
      tick();
      check("t2_done", done, 1'b1);
      check("t2_write_count", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            check("t2_addr", log_addr[k], k);
            check("t2_data", log_data[k], t2_words[k]);
         end
         check("t2_gap01", log_cyc[1] - log_cyc[0], 5);
         check("t2_gap12", log_cyc[2] - log_cyc[1], 5);
      end

      // Stall for 7 cycles after two bytes.
      clear_log();
      start_load(11'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      byte_valid = 1'b0;
      byte_data  = 8'hEE;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("t3_stall_no_write", enable_w, 1'b0);
      end
      check("t3_stall_ready", byte_ready, 1'b1);
      check("t3_stall_busy", busy, 1'b1);
      send_byte(8'hCC);
      send_byte(8'hDD);
      byte_valid = 1'b0;
      check("t3_enable_w", enable_w, 1'b1);
      check("t3_addr_w", addr_w, 10'd0);
      check("t3_q_w", q_w, 32'hDDCCBBAA);
      tick();
      check("t3_done", done, 1'b1);
      check("t3_write_count", log_addr.size(), 1);

      // Reset in the middle of a word.
      clear_log();
      start_load(11'd2);
      send_byte(8'h11);
      send_byte(8'h22);
      byte_valid = 1'b0;
      rst_n      = 1'b0;
      #1;
      check("t4_async_busy", busy, 1'b0);
      check("t4_async_ready", byte_ready, 1'b0);
      check("t4_async_q_w", q_w, '0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("t4_idle_done", done, 1'b0);
      check("t4_idle_busy", busy, 1'b0);
      check("t4_no_write", log_addr.size(), 0);

      // Zero-length load from IDLE.
      start_load(11'd0);
      check("t5_done", done, 1'b1);
      check("t5_busy", busy, 1'b0);
      check("t5_core_rst", core_reset_n, 1'b1);
      tick();
      tick();
      check("t5_no_write", log_addr.size(), 0);

      // Restart from DONE with a fresh word.
      start_load(11'd1);
      check("t6_core_rst", core_reset_n, 1'b0);
      check("t6_busy", busy, 1'b1);
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66);
      send_byte(8'h77);
      byte_valid = 1'b0;
      check("t6_enable_w", enable_w, 1'b1);
      check("t6_addr_w", addr_w, 10'd0);
      check("t6_q_w", q_w, 32'h77665544);
      tick();
      check("t6_done", done, 1'b1);

      // Full memory, with a START pulse mid-load that must be ignored.
      clear_log();
      start_load(11'd1024);
      for (int k = 0; k < 1024; k++) begin
         if (k == 500) begin
            start      = 1'b1;
            word_count = 11'd5;
         end
         send_byte(8'(k));
         start = 1'b0;
         send_byte({6'b0, 2'(k >> 8)});
         send_byte(8'hA5);
         send_byte(8'h5A);
      end
      byte_valid = 1'b0;
      tick();
      check("t7_done", done, 1'b1);
      check("t7_write_count", log_addr.size(), 1024);
      if (log_addr.size() == 1024) begin
         check("t7_last_addr", log_addr[1023], 1023);
         check("t7_last_data", log_data[1023], 32'h5AA503FF);
         bad = 0;
         for (int k = 0; k < 1024; k++) begin
            if (log_addr[k] != k || log_data[k] != {16'h5AA5, 6'b0, 10'(k)}) bad++;
         end
         check("t7_sequence", bad, 0);
      end

      // Oversized count is clamped to the memory size.
      clear_log();
      start_load(11'h7FF);
      for (int k = 0; k < 1024 * 4; k++) send_byte(8'(k));
      byte_valid = 1'b0;
      tick();
      check("t8_done", done, 1'b1);
      check("t8_write_count", log_addr.size(), 1024);
      if (log_addr.size() == 1024) check("t8_last_addr", log_addr[1023], 1023);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_prog_loader
